// File: rtl/sun.sv
// ---------------------------------------------------------------------------
// sun : bus slave model of a four-quadrant sun sensor.
//   Software enables the sensor, writes photodiode intensities A..D, and the
//   write of D kicks off a short pipeline that produces the X error, Y error
//   and total intensity.  Status and results are read back over the bus.
//
// Ports
//   pclk      in   1   clock, rising edge
//   psels     in   1   slave select
//   penables  in   1   access phase strobe
//   pwrites   in   1   1 = write, 0 = read
//   paddrs    in   32  byte address (bits 31:4 must be zero)
//   pwdatas   in   32  write data
//   prdatas   out  32  read data (0 unless selected for a read)
//   preadys   out  1   transfer complete (zero wait states)
//   reset     in   1   asynchronous, active-low reset
//
// state  | meaning
// IDLE   | waiting for a D write while enabled
// LOAD   | snapshot A..D so later bus writes cannot disturb the run
// SUM    | form the pair sums and the total
// DIFF   | form X and Y from the pair sums
// DONE   | publish results and raise VALID
// ---------------------------------------------------------------------------
module sun (
  input  logic        pclk,
  input  logic        psels,
  input  logic        penables,
  input  logic        pwrites,
  input  logic [31:0] paddrs,
  input  logic [31:0] pwdatas,
  output logic [31:0] prdatas,
  output logic        preadys,
  input  logic        reset
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUM,
    S_DIFF,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_en;
  logic        r_valid;
  logic [7:0]  r_pd_a, r_pd_b, r_pd_c, r_pd_d;
  logic [7:0]  r_s_a, r_s_b, r_s_c, r_s_d;
  logic [9:0]  r_ab, r_cd, r_ad, r_bc, r_tot;
  logic [9:0]  r_dx, r_dy, r_dsum;
  logic [9:0]  r_x, r_y, r_sum;

  logic        w_wr;
  logic        w_mapped;
  logic        w_wr_ctrl;
  logic        w_wr_d;
  logic        w_busy;
  logic        w_start;
  logic        w_abort;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused  = ^pwdatas[31:8];

  assign w_wr      = psels & penables & pwrites;
  assign w_mapped  = (paddrs[31:4] == 28'd0);
  assign w_wr_ctrl = w_wr & w_mapped & (paddrs[3:0] == 4'h0);
  assign w_wr_d    = w_wr & w_mapped & (paddrs[3:0] == 4'h4);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_wr_d & r_en & ~w_busy;
  // Clearing EN mid-run drops the run; results from the previous run stay.
  assign w_abort   = w_wr_ctrl & ~pwdatas[0] & w_busy;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_SUM;
      S_SUM:   w_next = S_DIFF;
      S_DIFF:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Bus-visible registers
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_pd_a <= 8'd0;
      r_pd_b <= 8'd0;
      r_pd_c <= 8'd0;
      r_pd_d <= 8'd0;
    end else if (w_wr && w_mapped) begin
      case (paddrs[3:0])
        4'h0:    r_en   <= pwdatas[0];
        4'h1:    r_pd_a <= pwdatas[7:0];
        4'h2:    r_pd_b <= pwdatas[7:0];
        4'h3:    r_pd_c <= pwdatas[7:0];
        4'h4:    r_pd_d <= pwdatas[7:0];
        default: ;
      endcase
    end
  end

  // Computation pipeline
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_s_a   <= 8'd0;
      r_s_b   <= 8'd0;
      r_s_c   <= 8'd0;
      r_s_d   <= 8'd0;
      r_ab    <= 10'd0;
      r_cd    <= 10'd0;
      r_ad    <= 10'd0;
      r_bc    <= 10'd0;
      r_tot   <= 10'd0;
      r_dx    <= 10'd0;
      r_dy    <= 10'd0;
      r_dsum  <= 10'd0;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_sum   <= 10'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_s_a <= r_pd_a;
          r_s_b <= r_pd_b;
          r_s_c <= r_pd_c;
          r_s_d <= r_pd_d;
        end
        S_SUM: begin
          r_ab  <= {2'b00, r_s_a} + {2'b00, r_s_b};
          r_cd  <= {2'b00, r_s_c} + {2'b00, r_s_d};
          r_ad  <= {2'b00, r_s_a} + {2'b00, r_s_d};
          r_bc  <= {2'b00, r_s_b} + {2'b00, r_s_c};
          r_tot <= {2'b00, r_s_a} + {2'b00, r_s_b} + {2'b00, r_s_c} + {2'b00, r_s_d};
        end
        S_DIFF: begin
          // 10-bit two's complement covers -510..+510
          r_dx   <= r_ab - r_cd;
          r_dy   <= r_ad - r_bc;
          r_dsum <= r_tot;
        end
        S_DONE: begin
          if (!w_abort) begin
            r_x   <= r_dx;
            r_y   <= r_dy;
            r_sum <= r_dsum;
          end
        end
        default: ;
      endcase

      if (w_start || w_abort)        r_valid <= 1'b0;
      else if (r_state == S_DONE)    r_valid <= 1'b1;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_mapped) begin
      case (paddrs[3:0])
        4'h0:    w_rdata = {31'd0, r_en};
        4'h1:    w_rdata = {24'd0, r_pd_a};
        4'h2:    w_rdata = {24'd0, r_pd_b};
        4'h3:    w_rdata = {24'd0, r_pd_c};
        4'h4:    w_rdata = {24'd0, r_pd_d};
        4'h5:    w_rdata = {29'd0, r_en, w_busy, r_valid};
        4'h6:    w_rdata = {{22{r_x[9]}}, r_x};
        4'h7:    w_rdata = {{22{r_y[9]}}, r_y};
        4'h8:    w_rdata = {22'd0, r_sum};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign prdatas = (psels & ~pwrites) ? w_rdata : 32'd0;
  assign preadys = psels & penables;

endmodule

// File: tb/tb_sun.sv
// ---------------------------------------------------------------------------
// tb_sun : directed bench for the sun sensor bus slave.
// ---------------------------------------------------------------------------
module tb_sun;

  logic        pclk;
  logic        psels;
  logic        penables;
  logic        pwrites;
  logic [31:0] paddrs;
  logic [31:0] pwdatas;
  logic [31:0] prdatas;
  logic        preadys;
  logic        reset;

  int n_pass  = 0;
  int n_total = 0;

  sun u_dut (
    .pclk     (pclk),
    .psels    (psels),
    .penables (penables),
    .pwrites  (pwrites),
    .paddrs   (paddrs),
    .pwdatas  (pwdatas),
    .prdatas  (prdatas),
    .preadys  (preadys),
    .reset    (reset)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called just after a rising edge; commit happens on the second edge.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    psels = 1'b1; penables = 1'b0; pwrites = 1'b1; paddrs = a; pwdatas = d;
    #1 check("pready_setup", {31'd0, preadys}, 32'd0);
    @(posedge pclk); #1 penables = 1'b1;
    #1 check("pready_access", {31'd0, preadys}, 32'd1);
    @(posedge pclk); #1 psels = 1'b0; penables = 1'b0; pwrites = 1'b0;
    #1 check("pready_idle", {31'd0, preadys}, 32'd0);
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    psels = 1'b1; penables = 1'b0; pwrites = 1'b0; paddrs = a;
    @(posedge pclk); #1 penables = 1'b1;
    #1 d = prdatas;
    @(posedge pclk); #1 psels = 1'b0; penables = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; psels = 1'b0; penables = 1'b0; pwrites = 1'b0;
    paddrs = 32'd0; pwdatas = 32'd0;
    #22;
    check("rst_prdata", prdatas, 32'd0);
    check("rst_pready", {31'd0, preadys}, 32'd0);
    @(posedge pclk); #1 reset = 1'b1;
    rd_chk("status_reset", 32'h5, 32'h0);

    // enable
    apb_wr(32'h0, 32'h1);
    rd_chk("status_en", 32'h5, 32'h4);
    rd_chk("ctrl_rd", 32'h0, 32'h1);

    // PD register width
    apb_wr(32'h1, 32'h0F);
    rd_chk("pd_a_0f", 32'h1, 32'h0000000F);
    apb_wr(32'h1, 32'h1234);
    rd_chk("pd_a_trunc", 32'h1, 32'h00000034);

    // main computation: A=15 B=255 C=255 D=10
    apb_wr(32'h2, 32'hFF);
    apb_wr(32'h3, 32'hFF);
    apb_wr(32'h1, 32'h0F);
    apb_wr(32'h4, 32'h0A);
    // hold a read select on STATUS and watch cycle by cycle from the start edge
    psels = 1'b1; pwrites = 1'b0; penables = 1'b0; paddrs = 32'h5;
    #1 check("busy_load", prdatas, 32'h6);
    repeat (3) @(posedge pclk);
    #1 check("busy_done", prdatas, 32'h6);
    @(posedge pclk);
    #1 check("valid_edge4", prdatas, 32'h5);
    psels = 1'b0;
    rd_chk("x_main", 32'h6, 32'h00000005);
    rd_chk("y_main", 32'h7, 32'hFFFFFE1B);
    rd_chk("sum_main", 32'h8, 32'h00000217);
    rd_chk("status_main", 32'h5, 32'h5);

    // abort: A=1 B=2 C=3 D=4, then EN=0 two clocks after start
    apb_wr(32'h1, 32'h1);
    apb_wr(32'h2, 32'h2);
    apb_wr(32'h3, 32'h3);
    apb_wr(32'h4, 32'h4);
    apb_wr(32'h0, 32'h0);
    rd_chk("status_abort", 32'h5, 32'h0);
    repeat (4) @(posedge pclk); #1;
    rd_chk("status_abort_late", 32'h5, 32'h0);
    rd_chk("x_kept", 32'h6, 32'h00000005);
    rd_chk("y_kept", 32'h7, 32'hFFFFFE1B);
    rd_chk("sum_kept", 32'h8, 32'h00000217);

    // D write with EN=0: stored, no start
    apb_wr(32'h4, 32'h22);
    rd_chk("status_noen", 32'h5, 32'h0);
    rd_chk("pd_d_noen", 32'h4, 32'h22);

    // unmapped address must not alias CTRL
    apb_wr(32'h20, 32'hFF);
    rd_chk("unmapped_rd", 32'h20, 32'h0);
    rd_chk("ctrl_after_unmapped", 32'h0, 32'h0);
    rd_chk("pd_a_after_unmapped", 32'h1, 32'h1);

    // run with A..D = 1,2,3,4 and a D write during BUSY
    apb_wr(32'h0, 32'h1);
    apb_wr(32'h4, 32'h4);
    apb_wr(32'h4, 32'h50);
    rd_chk("status_busy_wr", 32'h5, 32'h6);
    rd_chk("status_norestart", 32'h5, 32'h5);
    rd_chk("x_small", 32'h6, 32'hFFFFFFFC);
    rd_chk("y_small", 32'h7, 32'h00000000);
    rd_chk("sum_small", 32'h8, 32'h0000000A);
    rd_chk("pd_d_busy_wr", 32'h4, 32'h50);

    // reset mid-computation
    apb_wr(32'h4, 32'h04);
    @(posedge pclk); #2 reset = 1'b0;
    #1 psels = 1'b1; pwrites = 1'b0; paddrs = 32'h5;
    #1 check("midrst_status", prdatas, 32'h0);
    paddrs = 32'h8;
    #1 check("midrst_sum", prdatas, 32'h0);
    paddrs = 32'h1;
    #1 check("midrst_pd_a", prdatas, 32'h0);
    paddrs = 32'h0;
    #1 check("midrst_ctrl", prdatas, 32'h0);
    psels = 1'b0;
    @(posedge pclk); #1 reset = 1'b1;
    repeat (5) @(posedge pclk); #1;
    rd_chk("postrst_status", 32'h5, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
